// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int NUM_BYTES    = 2,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  localparam int IDX_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_BYTES*DATA_BITS-1:0] data,
  output logic                           tx,
  output logic                           busy,
  output logic                           byte_done,
  output logic                           frame_done,
  output logic [IDX_W-1:0]               byte_idx
);

  localparam int FRAME_W = NUM_BYTES * DATA_BITS;
  localparam int POS_W   = $clog2(FRAME_W);
  localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W   = 4;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(NUM_BYTES - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (NUM_BYTES < 1 || CLKS_PER_BIT < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_frame: illegal NUM_BYTES, CLKS_PER_BIT or PARITY_ODD");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_e;

  function automatic logic byte_parity(input logic [FRAME_W-1:0] frame,
                                       input logic [IDX_W-1:0]   idx);
    logic             p;
    logic [POS_W-1:0] pos;
    p = (PARITY_ODD != 0);
    for (int i = 0; i < DATA_BITS; i++) begin
      pos = POS_W'(32'(idx) * DATA_BITS + i);
      p   = p ^ frame[pos];
    end
    return p;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [IDX_W-1:0]   byte_q, byte_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               tx_q, tx_d, busy_q, busy_d;
  logic               byte_done_q, byte_done_d, frame_done_q, frame_done_d;
  logic [IDX_W-1:0]   byte_idx_q;
  logic               baud_tc_s;
  logic [POS_W-1:0]   bit_pos_s;

  assign baud_tc_s = (baud_q == BAUD_LAST);

  // Sequencer: baud counter inside bit counter inside byte counter.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          data_d  = data;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_tc_s) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_tc_s) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tc_s) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_tc_s) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Last stop bit: either chain straight into the next start bit or finish.
            if (byte_q == BYTE_LAST) begin
              state_d = S_IDLE;
              byte_d  = '0;
            end else begin
              state_d = S_START;
              byte_d  = byte_q + IDX_W'(1);
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
    endcase
  end

  assign bit_pos_s = POS_W'(32'(byte_d) * DATA_BITS + 32'(bit_d));

  // Output values for the next cycle, so every output leaves a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_pos_s];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = byte_parity(data_q, byte_d);
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d       = (state_d != S_IDLE);
    byte_done_d  = (state_d == S_STOP) && (bit_d == STOP_LAST) && (baud_d == BAUD_LAST);
    frame_done_d = byte_done_d && (byte_d == BYTE_LAST);
  end

  // State, counters, payload shadow and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      data_q       <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      byte_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      byte_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      data_q       <= data_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      byte_done_q  <= byte_done_d;
      frame_done_q <= frame_done_d;
      byte_idx_q   <= byte_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign byte_done  = byte_done_q;
  assign frame_done = frame_done_q;
  assign byte_idx   = byte_idx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: a 2-byte 8-bit 4-clk/bit instance and a 3-byte 7-bit 2-stop 1-clk/bit instance.
module tb_uart_tx_frame;

  localparam int CPB_A = 4;
`ifdef UART_TX_PARITY_EN
  localparam int    P      = 1;
  localparam string WIRE_A = "0001111001101010010111";
  localparam string WIRE_B = "010101010110111000011100111111011";
`else
  localparam int    P      = 0;
  localparam string WIRE_A = "00011110010101001011";
  localparam string WIRE_B = "010101011101110000110011111111";
`endif
  localparam int BYTE_A  = (10 + P) * CPB_A;
  localparam int FRAME_A = 2 * BYTE_A;
  localparam int BYTE_B  = 10 + P;
  localparam int C_RST   = BYTE_A + 2 * CPB_A + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [15:0] data_a;
  logic [20:0] data_b;
  logic        tx_a, busy_a, bd_a, fd_a, tx_b, busy_b, bd_b, fd_b;
  logic [0:0]  idx_a;
  logic [1:0]  idx_b;
  int          vectors = 0;
  int          miscompares = 0;

  uart_tx_frame #(.DATA_BITS(8), .NUM_BYTES(2), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data(data_a), .tx(tx_a), .busy(busy_a),
    .byte_done(bd_a), .frame_done(fd_a), .byte_idx(idx_a));

  uart_tx_frame #(.DATA_BITS(7), .NUM_BYTES(3), .CLKS_PER_BIT(1), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b), .tx(tx_b), .busy(busy_b),
    .byte_done(bd_b), .frame_done(fd_b), .byte_idx(idx_b));

  always #5 clk = ~clk;

  // Packed view: {tx, busy, byte_done, frame_done, byte_idx[1:0]}
  function automatic logic [5:0] obs(input int which);
    return (which == 0) ? {tx_a, busy_a, bd_a, fd_a, 1'b0, idx_a} : {tx_b, busy_b, bd_b, fd_b, idx_b};
  endfunction

  task automatic check(input string tag, input logic [5:0] observed, input logic [5:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Checks cycles 1..frame length after the accept edge; optionally pulses or holds start.
  task automatic run_frame(input int which, input string wire_bits, input int cpb, input int byte_len,
                           input int nbytes, input int pulse_at, input bit hold, input string name);
    logic [5:0] exp_v;
    for (int c = 1; c <= nbytes * byte_len; c++) begin
      exp_v = {wire_bits[(c - 1) / cpb] == "1", 1'b1, (c % byte_len) == 0, c == nbytes * byte_len,
               2'((c - 1) / byte_len)};
      check($sformatf("%s cyc %0d", name, c), obs(which), exp_v);
      if (which == 0) begin
        start_a = hold || (c == pulse_at);
        if (c == pulse_at) data_a = 16'hFFFF;
      end else begin
        start_b = hold;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = 16'h0000; data_b = 21'h0;
    repeat (3) @(negedge clk);
    check("reset a", obs(0), 6'b100000);
    check("reset b", obs(1), 6'b100000);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("idle a %0d", i), obs(0), 6'b100000);
      check($sformatf("idle b %0d", i), obs(1), 6'b100000);
    end

    data_a = 16'hA53C; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    run_frame(0, WIRE_A, CPB_A, BYTE_A, 2, 0, 1'b0, "basic");
    check("basic busy end", obs(0), 6'b100000);

    data_a = 16'hA53C; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    run_frame(0, WIRE_A, CPB_A, BYTE_A, 2, 30, 1'b0, "ignored start");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("not queued %0d", i), obs(0), 6'b100000);
      @(negedge clk);
    end

    data_a = 16'hA53C; start_a = 1'b1;
    @(negedge clk);
    run_frame(0, WIRE_A, CPB_A, BYTE_A, 2, 0, 1'b1, "held start");
    check("held gap idle", obs(0), 6'b100000);
    @(negedge clk);
    check("held relaunch", obs(0), 6'b010000);
    start_a = 1'b0;
    repeat (C_RST - 1) @(negedge clk);
    check("pre-reset byte1", obs(0), {WIRE_A[(C_RST - 1) / CPB_A] == "1", 5'b10001});
    rst = 1'b1;
    #1;
    check("async reset", obs(0), 6'b100000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < BYTE_A + 4; i++) begin
      @(negedge clk);
      check($sformatf("post reset quiet %0d", i), obs(0), 6'b100000);
    end

    data_a = 16'hA53C; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    run_frame(0, WIRE_A, CPB_A, BYTE_A, 2, 0, 1'b0, "after reset");
    check("after reset end", obs(0), 6'b100000);

    data_b = {7'h7E, 7'h07, 7'h55}; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    run_frame(1, WIRE_B, 1, BYTE_B, 3, 0, 1'b0, "three byte");
    check("three byte idle", obs(1), 6'b100000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
